dht11_reader: RTL and testbench

- Single-wire DHT11 bus master.
- On a start request it issues the host start pulse, then times the sensor response and the 40 data bits on the open-drain line, and verifies the checksum.
- Delivers the 40-bit frame as a one-cycle pulse on data. The sensor top's holding register and the 5-byte UART serialiser consume this pulse, and both treat nonzero data as "new frame".
- Sits between the start sources (debounced button OR UART 'r' command) and those consumers.

---
 rtl/dht11_reader.sv | 204 ++++++++++++++++++++
 tb/tb_dht11_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire bus master: issues the host start pulse, times the response and 40 data bits, verifies checksum.
// Latency: data/valid rise 3 clk after the pin edge that ends bit 40; start pulse lasts START_LOW_US (+/-1 us).
// Backpressure: none; start requests outside IDLE (including cooldown) are dropped, results are single-cycle pulses.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   btn_start start request level; its rising edge is the request
//   dht_io    open-drain sensor line (driven 0 or Z only, external pull-up)
//   data      {hum_int, hum_dec, tmp_int, tmp_dec, checksum}, nonzero for one cycle on success, else 0
//   valid     one-cycle pulse with a good frame
//   chk_err   one-cycle pulse on checksum mismatch
//   tmo_err   one-cycle pulse when an expected edge never arrives
//   busy      high in every state except IDLE
module dht11_reader #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned BIT_THRESH_US = 40,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned COOLDOWN_US   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    inout  wire         dht_io,
    output logic [39:0] data,
    output logic        valid,
    output logic        chk_err,
    output logic        tmo_err,
    output logic        busy
);

    localparam int unsigned PRE_TC   = CLK_HZ / 1_000_000 - 1;
    localparam int unsigned PRE_W    = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
    localparam int unsigned US_MAX_A = (START_LOW_US > COOLDOWN_US) ? START_LOW_US : COOLDOWN_US;
    localparam int unsigned US_MAX_B = (TIMEOUT_US > BIT_THRESH_US + 1) ? TIMEOUT_US : BIT_THRESH_US + 1;
    localparam int unsigned US_MAX   = (US_MAX_A > US_MAX_B) ? US_MAX_A : US_MAX_B;
    localparam int unsigned US_W     = $clog2(US_MAX + 1);

    typedef enum logic [3:0] {
        IDLE,
        START,
        REL,
        RESP_L,
        RESP_H,
        BIT_L,
        BIT_H,
        CHECK,
        COOL
    } state_t;

    state_t            state_q, state_d;
    logic [PRE_W-1:0]  pre_q;
    logic [US_W-1:0]   us_q;
    logic [5:0]        cnt_q;
    logic [38:0]       shift_q;
    logic              btn_prev_q;
    logic              sync1_q, sync2_q, line_prev_q;
    logic              drive_q;
    logic [39:0]       data_q;
    logic              valid_q, chk_err_q, tmo_err_q, busy_q;

    logic              tick;
    logic              req;
    logic              line_fall, line_rise;
    logic              bit_val;
    logic [39:0]       frame_nxt;
    logic [7:0]        sum;
    logic              sum_ok;
    logic              last_bit;
    logic              wait_state;
    logic              advance;
    logic              tmo_hit;

    // Open-drain: only ever pull low, otherwise release to the pull-up.
    assign dht_io = drive_q ? 1'b0 : 1'bz;

    assign tick      = (pre_q == PRE_W'(PRE_TC));
    assign req       = btn_start & ~btn_prev_q;
    assign line_fall = line_prev_q & ~sync2_q;
    assign line_rise = ~line_prev_q & sync2_q;

    // Bit value and the completed frame are evaluated in BIT_H so the result can be
    // registered on the same edge that ends bit 40.
    assign bit_val   = (us_q > US_W'(BIT_THRESH_US));
    assign frame_nxt = {shift_q, bit_val};
    assign sum       = frame_nxt[39:32] + frame_nxt[31:24] + frame_nxt[23:16] + frame_nxt[15:8];
    assign sum_ok    = (sum == frame_nxt[7:0]);
    assign last_bit  = (cnt_q == 6'd39);

    always_comb begin
        state_d    = state_q;
        wait_state = 1'b0;
        advance    = 1'b0;
        case (state_q)
            IDLE:   if (req) state_d = START;
            START:  if (us_q >= US_W'(START_LOW_US)) state_d = REL;
            REL: begin
                wait_state = 1'b1;
                advance    = line_fall;
                if (line_fall) state_d = RESP_L;
            end
            RESP_L: begin
                wait_state = 1'b1;
                advance    = line_rise;
                if (line_rise) state_d = RESP_H;
            end
            RESP_H: begin
                wait_state = 1'b1;
                advance    = line_fall;
                if (line_fall) state_d = BIT_L;
            end
            BIT_L: begin
                wait_state = 1'b1;
                advance    = line_rise;
                if (line_rise) state_d = BIT_H;
            end
            BIT_H: begin
                wait_state = 1'b1;
                advance    = line_fall;
                if (line_fall) state_d = last_bit ? CHECK : BIT_L;
            end
            CHECK:  state_d = COOL;
            COOL:   if (us_q >= US_W'(COOLDOWN_US)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // An edge arriving on the same cycle as the limit still wins.
        tmo_hit = wait_state & ~advance & (us_q >= US_W'(TIMEOUT_US));
        if (tmo_hit) state_d = COOL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pre_q       <= '0;
            us_q        <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            btn_prev_q  <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
            drive_q     <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            chk_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= btn_start;
            sync1_q     <= dht_io;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
            pre_q       <= tick ? '0 : pre_q + PRE_W'(1);

            // Time in state: restart on every state change, saturate at all-ones.
            if (state_d != state_q) begin
                us_q <= '0;
            end else if (tick && (us_q != '1)) begin
                us_q <= us_q + US_W'(1);
            end

            // Output registers follow the next state so they line up with state_q.
            busy_q    <= (state_d != IDLE);
            drive_q   <= (state_d == START);
            data_q    <= '0;
            valid_q   <= 1'b0;
            chk_err_q <= 1'b0;
            tmo_err_q <= 1'b0;

            if ((state_q == IDLE) && (state_d == START)) begin
                shift_q <= '0;
                cnt_q   <= '0;
            end

            if ((state_q == BIT_H) && line_fall) begin
                shift_q <= frame_nxt[38:0];
                cnt_q   <= cnt_q + 6'd1;
                if (last_bit) begin
                    if (sum_ok) begin
                        valid_q <= 1'b1;
                        data_q  <= frame_nxt;
                    end else begin
                        chk_err_q <= 1'b1;
                    end
                end
            end

            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
                shift_q   <= '0;
                cnt_q     <= '0;
            end
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign chk_err = chk_err_q;
    assign tmo_err = tmo_err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Directed bench for dht11_reader with a behavioural DHT11 sensor on an open-drain line.
// Time is scaled: 2 clocks per microsecond, 50 us start pulse, 300 us cooldown.
// All driving and sampling happens on the falling clock edge.
module tb_dht11_reader;

    localparam int unsigned CLK_HZ      = 2_000_000;
    localparam int unsigned START_LOW   = 50;
    localparam int unsigned TIMEOUT     = 200;
    localparam int unsigned COOLDOWN    = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic        sens_drive = 1'b0;
    wire         dht_io;
    logic [39:0] data;
    logic        valid, chk_err, tmo_err, busy;

    int tests = 0;
    int fails = 0;

    int          n_valid = 0, n_chk = 0, n_tmo = 0, n_start = 0, n_glitch = 0;
    logic [39:0] last_data = '0;
    logic        busy_prev = 1'b0;

    assign dht_io = sens_drive ? 1'b0 : 1'bz;
    pullup (dht_io);

    always #5 clk = ~clk;

    dht11_reader #(
        .CLK_HZ       (CLK_HZ),
        .START_LOW_US (START_LOW),
        .BIT_THRESH_US(40),
        .TIMEOUT_US   (TIMEOUT),
        .COOLDOWN_US  (COOLDOWN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .dht_io   (dht_io),
        .data     (data),
        .valid    (valid),
        .chk_err  (chk_err),
        .tmo_err  (tmo_err),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (valid) begin
            n_valid   = n_valid + 1;
            last_data = data;
        end
        if (chk_err) n_chk = n_chk + 1;
        if (tmo_err) n_tmo = n_tmo + 1;
        if (!valid && data !== 40'h0) n_glitch = n_glitch + 1;
        if (busy && !busy_prev) n_start = n_start + 1;
        busy_prev = busy;
    end

    task automatic wait_us(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    // Returns the length of the host low pulse in clocks, or -1 if none appears.
    task automatic wait_start_pulse(output int lc);
        int c;
        lc = -1;
        c  = 0;
        while (dht_io !== 1'b0 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        if (dht_io !== 1'b0) return;
        c = 0;
        while (dht_io === 1'b0 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        lc = c;
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy !== 1'b0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
    endtask

    // Sensor answer. Zero bits alternate 26 us and hi0b us high; ones are 70 us high.
    // With nbits < 40 the sensor stops 10 us into the high phase of bit nbits.
    // For a full frame the outputs are sampled 3 clocks after the final falling edge.
    task automatic sensor_reply(input logic [39:0] frame, input int hi0b, input int nbits,
                                output logic v3, output logic c3, output logic [39:0] d3);
        int lc;
        int hi;
        v3 = 1'b0;
        c3 = 1'b0;
        d3 = '0;
        wait_start_pulse(lc);
        tests++;
        if (lc < 98 || lc > 102) begin
            fails++;
            $display("FAIL start_pulse: low for %0d clk, required 98..102", lc);
        end
        if (lc < 0) return;
        wait_us(30);
        sens_drive = 1'b1; wait_us(80);
        sens_drive = 1'b0; wait_us(80);
        for (int i = 0; i < nbits; i++) begin
            sens_drive = 1'b1; wait_us(50);
            sens_drive = 1'b0;
            if (i == nbits - 1 && nbits < 40) hi = 10;
            else if (frame[39 - i])           hi = 70;
            else                              hi = (i % 2 == 1) ? hi0b : 26;
            wait_us(hi);
        end
        if (nbits == 40) begin
            sens_drive = 1'b1;
            repeat (3) @(negedge clk);
            v3 = valid;
            c3 = chk_err;
            d3 = data;
            wait_us(50);
            sens_drive = 1'b0;
        end
    endtask

    task automatic test_reset;
        tests++; if (data !== 40'h0)  begin fails++; $display("FAIL reset_data: got %h, required 0", data); end
        tests++; if (valid !== 1'b0)  begin fails++; $display("FAIL reset_valid: got %b, required 0", valid); end
        tests++; if (chk_err !== 1'b0) begin fails++; $display("FAIL reset_chk: got %b, required 0", chk_err); end
        tests++; if (tmo_err !== 1'b0) begin fails++; $display("FAIL reset_tmo: got %b, required 0", tmo_err); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests++; if (dht_io !== 1'b1) begin fails++; $display("FAIL reset_line: got %b, required 1 (released)", dht_io); end
    endtask

    task automatic test_good_frame;
        logic v3, c3;
        logic [39:0] d3;
        int nv, nc, nt, c;
        nv = n_valid; nc = n_chk; nt = n_tmo;
        btn_start = 1'b1;
        sensor_reply(40'h37_00_19_00_50, 26, 40, v3, c3, d3);
        tests++; if (v3 !== 1'b1) begin fails++; $display("FAIL good_valid_latency: got %b, required 1", v3); end
        tests++; if (d3 !== 40'h3700190050) begin fails++; $display("FAIL good_data: got %h, required 3700190050", d3); end
        tests++; if (c3 !== 1'b0) begin fails++; $display("FAIL good_chk: got %b, required 0", c3); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL good_busy_cool: got %b, required 1", busy); end
        wait_idle(c);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL good_idle: busy %b, required 0", busy); end
        tests++;
        if (n_valid - nv != 1 || n_chk != nc || n_tmo != nt) begin
            fails++;
            $display("FAIL good_pulses: valid %0d chk %0d tmo %0d, required 1 0 0", n_valid - nv, n_chk - nc, n_tmo - nt);
        end
        btn_start = 1'b0;
    endtask

    task automatic test_bad_checksum;
        logic v3, c3;
        logic [39:0] d3;
        int nv, nc, c;
        nv = n_valid; nc = n_chk;
        wait_us(5);
        btn_start = 1'b1;
        sensor_reply(40'h37_00_19_00_51, 26, 40, v3, c3, d3);
        tests++; if (c3 !== 1'b1) begin fails++; $display("FAIL bad_chk_pulse: got %b, required 1", c3); end
        tests++; if (v3 !== 1'b0 || d3 !== 40'h0) begin fails++; $display("FAIL bad_outputs: valid %b data %h, required 0 0", v3, d3); end
        wait_idle(c);
        tests++;
        if (n_valid != nv || n_chk - nc != 1) begin
            fails++;
            $display("FAIL bad_pulses: valid %0d chk %0d, required 0 1", n_valid - nv, n_chk - nc);
        end
        btn_start = 1'b0;
    endtask

    task automatic test_timeout;
        int lc, c, nt, nv;
        nt = n_tmo; nv = n_valid;
        wait_us(5);
        btn_start = 1'b1;
        wait_start_pulse(lc);
        c = 0;
        while (tmo_err !== 1'b1 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        tests++; if (c < 398 || c > 404) begin fails++; $display("FAIL tmo_time: %0d clk after release, required 398..404", c); end
        tests++; if (dht_io !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL tmo_line_busy: line %b busy %b, required 1 1", dht_io, busy); end
        wait_idle(c);
        tests++; if (c < 596 || c > 606) begin fails++; $display("FAIL tmo_cooldown: busy %0d clk after tmo, required 596..606", c); end
        tests++; if (n_tmo - nt != 1 || n_valid != nv) begin fails++; $display("FAIL tmo_pulses: tmo %0d valid %0d, required 1 0", n_tmo - nt, n_valid - nv); end
        btn_start = 1'b0;
    endtask

    task automatic test_bit_thresh;
        logic v3, c3;
        logic [39:0] d3;
        int c;
        wait_us(5);
        btn_start = 1'b1;
        sensor_reply(40'h12_34_56_78_14, 40, 40, v3, c3, d3);
        tests++; if (v3 !== 1'b1 || d3 !== 40'h1234567814) begin fails++; $display("FAIL bit_thresh: valid %b data %h, required 1 1234567814", v3, d3); end
        wait_idle(c);
        btn_start = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n0, lc, c;
        n0 = n_start;
        wait_us(5);
        btn_start = 1'b1;
        wait_start_pulse(lc);
        wait_us(20);  btn_start = 1'b0;
        wait_us(5);   btn_start = 1'b1;
        c = 0;
        while (tmo_err !== 1'b1 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        wait_us(100); btn_start = 1'b0;
        wait_us(5);   btn_start = 1'b1;
        wait_idle(c);
        wait_us(400);
        tests++; if (n_start - n0 != 1 || busy !== 1'b0) begin fails++; $display("FAIL held_level: starts %0d busy %b, required 1 0", n_start - n0, busy); end
        btn_start = 1'b0;
        wait_us(2);
        btn_start = 1'b1;
        wait_start_pulse(lc);
        wait_idle(c);
        tests++; if (n_start - n0 != 2) begin fails++; $display("FAIL new_edge: starts %0d, required 2", n_start - n0); end
        btn_start = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic v3, c3;
        logic [39:0] d3;
        int nv, nc, nt, c;
        wait_us(5);
        btn_start = 1'b1;
        sensor_reply(40'h37_00_19_00_50, 26, 20, v3, c3, d3);
        nv = n_valid; nc = n_chk; nt = n_tmo;
        #3 rst = 1'b1;
        #1;
        tests++;
        if (dht_io !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || data !== 40'h0 || chk_err !== 1'b0 || tmo_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: line %b busy %b valid %b data %h chk %b tmo %b, required 1 0 0 0 0 0",
                     dht_io, busy, valid, data, chk_err, tmo_err);
        end
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        wait_us(10);
        tests++; if (n_valid != nv || n_chk != nc || n_tmo != nt) begin fails++; $display("FAIL mid_reset_pulses: valid %0d chk %0d tmo %0d, required 0 0 0", n_valid - nv, n_chk - nc, n_tmo - nt); end
        btn_start = 1'b1;
        sensor_reply(40'h37_00_19_00_50, 26, 40, v3, c3, d3);
        tests++; if (v3 !== 1'b1 || d3 !== 40'h3700190050) begin fails++; $display("FAIL post_reset_frame: valid %b data %h, required 1 3700190050", v3, d3); end
        wait_idle(c);
        btn_start = 1'b0;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        test_reset;
        rst = 1'b0;
        wait_us(2);
        test_reset;
        test_good_frame;
        test_bad_checksum;
        test_timeout;
        test_bit_thresh;
        test_back_to_back;
        test_reset_mid;
        tests++; if (n_glitch != 0) begin fails++; $display("FAIL data_outside_valid: %0d cycles, required 0", n_glitch); end
        tests++; if (last_data !== 40'h3700190050) begin fails++; $display("FAIL last_frame: got %h, required 3700190050", last_data); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
